// File: rtl/lcd1602_responder.sv
// HD44780-style LCD1602 bus responder: latches instructions/characters on the
// falling edge of enable, keeps a 32-cell visible DDRAM and models busy timing.
module lcd1602_responder #(
    parameter int DATA_BITS         = 8,
    parameter int BUSY_CYCLES       = 4,
    parameter int CLEAR_BUSY_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rs,
    input  logic                 rw,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data,
    output logic [7:0]           rd_data,
    input  logic [4:0]           ddram_raddr,
    output logic [7:0]           ddram_rdata,
    output logic [6:0]           ac,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 two_line,
    output logic                 busy,
    output logic                 char_wr,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR_FILL, BUSY_WAIT} state_t;

    state_t      state;
    logic        en_q;
    logic        rs_q;
    logic        inc_mode;
    logic        clr_op;
    logic [7:0]  cmd_q;
    logic [4:0]  fill_idx;
    logic [15:0] cnt;
    logic [7:0]  cells [32];
    logic        latch;

    function automatic logic [6:0] adv(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    function automatic logic visible(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] cell_of(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // busy must already be high in the latch cycle itself, so it is not registered
    assign latch   = en_q & ~enable;
    assign busy    = (state != IDLE) | (latch & ~rw);
    assign rd_data = {busy, ac};

    always_ff @(posedge clk) begin
        ddram_rdata <= cells[ddram_raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            cmd_q      <= 8'h00;
            ac         <= 7'h00;
            inc_mode   <= 1'b1;
            clr_op     <= 1'b0;
            fill_idx   <= 5'd0;
            cnt        <= 16'd0;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            two_line   <= 1'b0;
            char_wr    <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
        end else begin
            en_q    <= enable;
            char_wr <= 1'b0;

            if (latch) begin
                if (state != IDLE) begin
                    err <= 1'b1;
                end else if (!rw) begin
                    rs_q  <= rs;
                    cmd_q <= 8'(data);
                    cnt   <= 16'd1;
                    state <= EXEC;
                end
            end

            case (state)
                EXEC: begin
                    cnt    <= cnt + 16'd1;
                    clr_op <= 1'b0;
                    state  <= BUSY_WAIT;
                    if (rs_q) begin
                        if (visible(ac)) begin
                            cells[cell_of(ac)] <= cmd_q;
                            char_wr            <= 1'b1;
                        end
                        ac <= adv(ac, inc_mode);
                    end else begin
                        casez (cmd_q)
                            8'b1???????: ac <= cmd_q[6:0];
                            8'b01??????: ;
                            8'b001?????: begin
                                two_line <= cmd_q[3];
                                if (!cmd_q[4]) err <= 1'b1;
                            end
                            8'b0001????: begin
                                if (cmd_q[3]) err <= 1'b1;
                                else          ac  <= adv(ac, cmd_q[2]);
                            end
                            8'b00001???: begin
                                display_on <= cmd_q[2];
                                cursor_on  <= cmd_q[1];
                                blink_on   <= cmd_q[0];
                            end
                            8'b000001??: begin
                                inc_mode <= cmd_q[1];
                                if (cmd_q[0]) err <= 1'b1;
                            end
                            8'b0000001?: ac <= 7'h00;
                            8'b00000001: begin
                                fill_idx <= 5'd0;
                                clr_op   <= 1'b1;
                                state    <= CLEAR_FILL;
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR_FILL: begin
                    cnt             <= cnt + 16'd1;
                    cells[fill_idx] <= 8'h20;
                    fill_idx        <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) begin
                        ac       <= 7'h00;
                        inc_mode <= 1'b1;
                        state    <= BUSY_WAIT;
                    end
                end
                BUSY_WAIT: begin
                    // cnt holds the busy cycles already spent, latch cycle included
                    cnt <= cnt + 16'd1;
                    if (cnt + 16'd1 >= (clr_op ? 16'(CLEAR_BUSY_CYCLES) : 16'(BUSY_CYCLES)))
                        state <= IDLE;
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
